pixel_writer: RTL
=================

Name: pixel_writer

Overview:
- Frame sink at the output end of the image path, the writer counterpart of the frame reader.
- Accepts a streamed RGB pixel sequence over a valid/ready handshake and tracks row/column position.
- Stores each frame in an internal byte buffer as interleaved R,G,B, the same layout the reader consumes.
- Flags frame completion, holds the frame until acknowledged, and exposes a synchronous readback port for the buffer.

Parameters:
- height, 120, frame rows.
- width, 160, frame columns.
- outFile, "out.hex", dump file path; used only with the optional feature.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  pixel present on in_r/in_g/in_b.
- in_ready  out  1  block can accept a pixel this cycle.
- in_sof  in  1  start of frame; qualified by in_valid.
- in_r  in  8  red byte.
- in_g  in  8  green byte.
- in_b  in  8  blue byte.
- frame_ack  in  1  single-cycle pulse; releases DONE.
- frame_done  out  1  full frame captured.
- sof_err  out  1  sticky; set when in_sof is accepted mid-frame.
- row  out  clog2(height)  row of the next pixel to be written.
- col  out  clog2(width)  column of the next pixel to be written.
- rd_addr  in  clog2(height*width*3)  readback byte address.
- rd_data  out  8  readback byte; 1-cycle latency.

Behaviour:
- Reset, asynchronous on rst_n low:
  - state=IDLE, in_ready=0, frame_done=0, sof_err=0, row=0, col=0, rd_data=0.
  - Buffer contents are not cleared.
- The handshake transfers a pixel when in_valid && in_ready on a posedge.
- Pixel p = row*width+col is written to addresses 3p (R), 3p+1 (G), 3p+2 (B) in the same cycle as the transfer. The buffer is 3 byte lanes or one 24-bit word; both are acceptable.
- in_ready is registered:
  - 1 in IDLE and CAPTURE.
  - 0 in DONE.
  - 0 for the first cycle after reset release.
- IDLE:
  - A transfer with in_sof=1 writes pixel 0, sets col=1 (or row=1, col=0 when width=1), and goes to CAPTURE.
  - A transfer with in_sof=0 is consumed and discarded: no write, no counter change.
- CAPTURE:
  - Each transfer writes at (row,col), then col increments.
  - At col=width-1, col wraps to 0 and row increments.
  - A transfer at row=height-1, col=width-1 writes the last pixel, resets row=col=0, and goes to DONE.
- CAPTURE with in_sof=1 on a transfer:
  - The pixel is written as pixel 0 and col=1 (restart).
  - sof_err is set if (row,col) != (0,0).
  - sof_err is cleared only by reset.
- DONE:
  - frame_done=1 and in_ready=0.
  - frame_ack goes to IDLE; frame_done drops and in_ready rises on the next cycle.
  - frame_ack outside DONE is ignored.
- Readback:
  - rd_data <= buffer[rd_addr] every cycle, in any state.
  - A read of the same address as a same-cycle write returns the old byte.
  - Addresses >= height*width*3 return 0.
- Throughput: 1 pixel/clock in CAPTURE, with no bubbles at row wrap.
- Latency: frame_done is high on the cycle after the last transfer.
- Reset mid-frame aborts immediately; the partial frame remains in the buffer and the next frame requires in_sof.

Optional Feature:
- Macro: PIXEL_WRITER_HEX_DUMP_EN.
- Defined: on the DONE entry cycle, the simulation writes the buffer with $writememh to outFile, bytes 0..height*width*3-1, one per line. This is the format the reader loads with $readmemh.
- Undefined: no file I/O; outFile is unused; RTL is fully synthesizable. Cycle behaviour is identical either way.

Test Plan:
- rst_n low mid-stream, then high -> all outputs at their reset values; in_ready=1 on the second cycle after release.
- Full 160x120 frame, continuous valid, in_sof on the first pixel, R=p[7:0], G=p[15:8], B=0x5A -> frame_done one cycle after pixel 19199. Readback addr 3 gives 0x01, addr 57599 gives 0x5A, addr 57597 gives 0xFF (19199 & 0xFF).
- Three pixels with in_sof=0 in IDLE, then in_sof frame -> dropped pixels never written; row/col start at 0.
- in_sof at pixel 500 of a frame -> sof_err=1; that pixel is stored at addr 0..2; frame_done after 19200 further pixels.
- Random in_valid gaps (50%) and frame_ack held off 10 cycles -> in_ready=0 throughout DONE; no writes; IDLE on the cycle after frame_ack.
- Readback of address 60000 -> rd_data=0; read and write to addr 0 in the same cycle -> old byte returned, new byte on the next read.

Source files
------------

// File: rtl/pixel_writer.sv
// rtl/pixel_writer.sv - frame sink: streams RGB pixels into an interleaved R,G,B byte buffer
//
// Purpose: accepts pixels over a valid/ready handshake, tracks (row,col), stores
// pixel p at bytes 3p/3p+1/3p+2, raises frame_done after the last pixel and holds
// the frame until frame_ack. A 1-cycle-latency readback port exposes the buffer.
//
// Ports:
//   clk, rst_n                 clock (posedge), asynchronous active-low reset
//   in_valid/in_ready          pixel handshake; in_sof/in_r/in_g/in_b qualify with in_valid
//   frame_ack                  pulse that releases a completed frame
//   frame_done, sof_err        frame captured / sticky in_sof-mid-frame flag
//   row, col                   position of the next pixel to be written
//   rd_addr, rd_data           byte readback, 1-cycle latency, 0 beyond the buffer
module pixel_writer #(
    parameter int height  = 120,
    parameter int width   = 160,
    parameter     outFile = "out.hex",
    localparam int NPIX   = height * width,
    localparam int NBYTES = NPIX * 3,
    localparam int RW     = (height > 1) ? $clog2(height) : 1,
    localparam int CW     = (width > 1) ? $clog2(width) : 1,
    localparam int PW     = (NPIX > 1) ? $clog2(NPIX) : 1,
    localparam int AW     = $clog2(NBYTES)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_sof,
    input  logic [7:0]    in_r,
    input  logic [7:0]    in_g,
    input  logic [7:0]    in_b,
    input  logic          frame_ack,
    output logic          frame_done,
    output logic          sof_err,
    output logic [RW-1:0] row,
    output logic [CW-1:0] col,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

    state_t        state_q, state_d;
    logic          started_q, started_d;
    logic          in_ready_q, in_ready_d;
    logic          frame_done_q, frame_done_d;
    logic          sof_err_q, sof_err_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [PW-1:0] pix_q, pix_d;
    logic [7:0]    rd_data_q, rd_data_d;

    // One 24-bit word per pixel, {B,G,R}; byte lane k of word p is byte 3p+k.
    logic [23:0]   mem [NPIX];

    logic          xfer;
    logic          take;
    logic          wr_en;
    logic [PW-1:0] wr_pix;
    logic [RW-1:0] cur_row;
    logic [CW-1:0] cur_col;
    logic [PW-1:0] cur_pix;
    logic [PW-1:0] rd_pix;
    logic [1:0]    rd_lane;
    logic [23:0]   rd_word;

    assign xfer    = in_valid && in_ready_q;
    assign rd_pix  = PW'(rd_addr / AW'(3));
    assign rd_lane = 2'(rd_addr % AW'(3));
    assign rd_word = mem[rd_pix];

    always_comb begin
        state_d      = state_q;
        started_d    = 1'b1;
        sof_err_d    = sof_err_q;
        row_d        = row_q;
        col_d        = col_q;
        pix_d        = pix_q;
        take         = 1'b0;
        cur_row      = row_q;
        cur_col      = col_q;
        cur_pix      = pix_q;
        wr_en        = 1'b0;
        wr_pix       = pix_q;
        rd_data_d    = 8'h00;

        // A pixel carrying in_sof is always pixel 0, whether it opens a frame
        // from IDLE or restarts one in CAPTURE.
        case (state_q)
            IDLE: begin
                if (xfer && in_sof) begin
                    take    = 1'b1;
                    cur_row = '0;
                    cur_col = '0;
                    cur_pix = '0;
                end
            end
            CAPTURE: begin
                if (xfer) begin
                    take = 1'b1;
                    if (in_sof) begin
                        cur_row = '0;
                        cur_col = '0;
                        cur_pix = '0;
                        if ((row_q != '0) || (col_q != '0)) begin
                            sof_err_d = 1'b1;
                        end
                    end
                end
            end
            DONE: begin
                if (frame_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (take) begin
            wr_en  = 1'b1;
            wr_pix = cur_pix;
            if (cur_pix == PW'(NPIX - 1)) begin
                row_d   = '0;
                col_d   = '0;
                pix_d   = '0;
                state_d = DONE;
            end else begin
                pix_d   = cur_pix + PW'(1);
                state_d = CAPTURE;
                if (cur_col == CW'(width - 1)) begin
                    col_d = '0;
                    row_d = cur_row + RW'(1);
                end else begin
                    col_d = cur_col + CW'(1);
                    row_d = cur_row;
                end
            end
        end

        // started_q holds in_ready low for the first cycle after reset release.
        in_ready_d   = started_q && (state_d != DONE);
        frame_done_d = (state_d == DONE);

        if (32'(rd_addr) < NBYTES) begin
            case (rd_lane)
                2'd0:    rd_data_d = rd_word[7:0];
                2'd1:    rd_data_d = rd_word[15:8];
                default: rd_data_d = rd_word[23:16];
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            started_q    <= 1'b0;
            in_ready_q   <= 1'b0;
            frame_done_q <= 1'b0;
            sof_err_q    <= 1'b0;
            row_q        <= '0;
            col_q        <= '0;
            pix_q        <= '0;
            rd_data_q    <= 8'h00;
        end else begin
            state_q      <= state_d;
            started_q    <= started_d;
            in_ready_q   <= in_ready_d;
            frame_done_q <= frame_done_d;
            sof_err_q    <= sof_err_d;
            row_q        <= row_d;
            col_q        <= col_d;
            pix_q        <= pix_d;
            rd_data_q    <= rd_data_d;
        end
    end

    // Buffer is not reset; a read racing a write to the same word sees the old data.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_pix] <= {in_b, in_g, in_r};
        end
    end

    assign in_ready   = in_ready_q;
    assign frame_done = frame_done_q;
    assign sof_err    = sof_err_q;
    assign row        = row_q;
    assign col        = col_q;
    assign rd_data    = rd_data_q;

endmodule
